spi_master: RTL and testbench
=============================

# spi_master

Byte-oriented SPI master: accepts one 8-bit word per valid pulse, shifts it out MSB first on MOSI while shifting in MISO, and returns the received byte with a one-cycle valid pulse. Sits under the SSD1306 display controller. It carries command bytes from the command ROM and pixel bytes from the frame RAM to the panel, and reads key events from the keyboard MISO line. The command ROM and frame RAM are separate blocks and are not part of this block.

## Interface
- SPI_MODE, default 0: 0..3; CPOL = mode[1] (modes 2, 3), CPHA = mode[0] (modes 1, 3).
- CLKS_PER_HALF_BIT, default 1: system clocks per SCLK half-period, ≥1.
- i_Clk  in  1  system clock; all logic on rising edge. One clock domain.
- i_Reset  in  1  synchronous, active-high reset.
- i_TX_Byte  in  8  byte to transmit; sampled only when accepted.
- i_TX_DV  in  1  one-cycle request pulse carrying i_TX_Byte.
- o_TX_Ready  out  1  high when idle and able to accept a request.
- o_RX_DV  out  1  one-cycle pulse; o_RX_Byte is valid.
- o_RX_Byte  out  8  last received byte; held until the next completion.
- o_SPI_Clk  out  1  SCLK; idles at CPOL.
- o_SPI_MOSI  out  1  serial data out.
- i_SPI_MISO  in  1  serial data in.

## Operation
- States: IDLE and XFER.
- IDLE: o_TX_Ready=1. If i_TX_DV=1, latch i_TX_Byte and go to XFER. Call this accepting edge t0.
- In XFER, i_TX_DV is ignored; the byte is not queued.
- XFER produces 16 SCLK toggles, k=1..16. Odd k is a leading edge; even k is a trailing edge.
- CPHA=0:
  - bit7 is driven onto MOSI at t0.
  - Bits 6..0 are driven at trailing edges k=2,4..14.
  - MISO is sampled at leading edges.
- CPHA=1:
  - Bits 7..0 are driven at leading edges k=1,3..15.
  - MISO is sampled at trailing edges.
- RX shifts in MSB first: the first sample becomes o_RX_Byte[7].
- After edge 16:
  - o_RX_Byte is updated and o_RX_DV=1 for exactly one cycle.
  - o_TX_Ready returns to 1 and the state returns to IDLE.
- MOSI holds its last bit in IDLE. SCLK is always CPOL in IDLE.
- Reset values (applied at any edge with i_Reset=1):
  - o_SPI_Clk=CPOL, o_SPI_MOSI=0.
  - o_RX_Byte=0, o_RX_DV=0, o_TX_Ready=0.
  - State is IDLE.
- o_TX_Ready becomes 1 at the first edge with i_Reset=0.
- Reset mid-transfer aborts at once, with no o_RX_DV pulse and no partial byte update.

## Timing
- Let N = CLKS_PER_HALF_BIT. All outputs are registered.
- Toggle k is visible after edge t0+k·N. MISO is sampled at that same edge, using the value present just before it.
- o_TX_Ready=0 after t0 through edge t0+16N. o_RX_DV and o_TX_Ready=1 are visible after t0+16N.
- Transfer occupies 16N cycles. Back-to-back transfers are allowed: DV asserted in the o_RX_DV cycle is accepted, so one byte costs 16N+1 cycles.
- MOSI setup before a sampling edge is ≥N cycles.
- Width rules:
  - Half-bit counter is $clog2(N)+1 bits and wraps at N-1.
  - Edge counter is 5 bits, loaded with 16 and counted to 0.
  - TX/RX shift index is 3 bits.

## Structure
- Shared package (spi_pkg):
  - SPI mode encoding.
  - cpol(mode) and cpha(mode) helper functions.
  - The 16-edge constant.
- One natural sub-module, spi_sclk_gen:
  - Inputs: start, N.
  - Outputs: SCLK level, leading/trailing edge strobes, done.
  - spi_master holds the shift registers, MOSI/MISO logic and the handshake.

## Test plan
- Mode 0, N=1, MISO looped to MOSI, send 0xA5:
  - SCLK shows 8 rising edges, MOSI 1,0,1,0,0,1,0,1.
  - o_RX_Byte=0xA5 with one o_RX_DV pulse 16 cycles after t0.
  - o_TX_Ready low for exactly 16 cycles.
- Mode 3, N=4, MISO driven with 0x3C bit by bit:
  - SCLK idles high; 64-cycle transfer; o_RX_Byte=0x3C.
  - MOSI changes only on falling (leading) SCLK edges.
- Back-to-back 0x00 then 0xFF, second DV in the o_RX_DV cycle:
  - Both accepted; 2 RX pulses 17 cycles apart (N=1).
- DV pulsed at cycle t0+5 during a transfer:
  - Ignored; exactly one o_RX_DV.
  - The byte on i_TX_Byte at t0+5 is never transmitted.
- i_Reset asserted at t0+8 (mode 0, N=2):
  - Next cycle SCLK=0, MOSI=0, o_TX_Ready=0, no o_RX_DV.
  - Ready=1 one cycle after reset release; a new 0x81 transfer completes correctly.
- Mode 1 vs mode 2 with the same MISO stream 0x96:
  - Both return 0x96.
  - Idle SCLK is 0 in mode 1 and 1 in mode 2.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the byte-oriented SPI master.
//   spi_mode_e  : SPI mode encoding (bit 1 = CPOL, bit 0 = CPHA)
//   spi_state_e : handshake/transfer state of spi_master
//   SPI_EDGES   : SCLK toggles per byte (two per bit)
//   EDGE_CNT_W  : width of the edge down-counter (holds SPI_EDGES)
//   cpol()/cpha(): split a mode into clock polarity and phase
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_MODE_0 = 2'd0,
    SPI_MODE_1 = 2'd1,
    SPI_MODE_2 = 2'd2,
    SPI_MODE_3 = 2'd3
  } spi_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } spi_state_e;

  localparam int SPI_EDGES  = 16;
  localparam int EDGE_CNT_W = 5;

  function automatic logic cpol(input spi_mode_e mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input spi_mode_e mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator for one byte transfer.
//   i_Clk, i_Reset : system clock, synchronous active-high reset
//   start          : one-cycle pulse that begins a 16-toggle burst
//   sclk           : registered SCLK level, idles at CPOL
//   lead / trail   : combinational strobes, high in the cycle whose rising
//                    i_Clk edge performs a leading / trailing SCLK toggle
//   done           : high together with the final (16th) toggle strobe
// Toggle k of a burst lands on the edge start+k*CLKS_PER_HALF_BIT.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int   CLKS_PER_HALF_BIT = 1,
  parameter logic CPOL              = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic start,
  output logic sclk,
  output logic lead,
  output logic trail,
  output logic done
);

  localparam int                    HW       = $clog2(CLKS_PER_HALF_BIT) + 1;
  localparam logic [HW-1:0]         HALF_MAX = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [EDGE_CNT_W-1:0] EDGES    = EDGE_CNT_W'(SPI_EDGES);

  logic [HW-1:0]         half_cnt;
  logic [EDGE_CNT_W-1:0] edge_cnt;
  logic                  tick;

  // edge_cnt counts down from 16; even remaining count means odd k (leading)
  assign tick  = (edge_cnt != '0) && (half_cnt == HALF_MAX);
  assign lead  = tick && !edge_cnt[0];
  assign trail = tick && edge_cnt[0];
  assign done  = tick && (edge_cnt == EDGE_CNT_W'(1));

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      half_cnt <= '0;
      edge_cnt <= '0;
      sclk     <= CPOL;
    end else if (start) begin
      half_cnt <= '0;
      edge_cnt <= EDGES;
      sclk     <= CPOL;
    end else if (edge_cnt != '0) begin
      if (tick) begin
        half_cnt <= '0;
        edge_cnt <= edge_cnt - EDGE_CNT_W'(1);
        sclk     <= ~sclk;
      end else begin
        half_cnt <= half_cnt + HW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master, MSB first, full duplex.
//   i_Clk, i_Reset : system clock, synchronous active-high reset
//   i_TX_Byte      : byte to send, captured when a request is accepted
//   i_TX_DV        : one-cycle request strobe
//   o_TX_Ready     : idle and able to accept a request
//   o_RX_DV        : one-cycle strobe, o_RX_Byte just updated
//   o_RX_Byte      : last received byte, held until the next completion
//   o_SPI_Clk      : SCLK, idles at CPOL
//   o_SPI_MOSI     : serial out, holds its last bit while idle
//   i_SPI_MISO     : serial in
// Parameters: SPI_MODE (0..3), CLKS_PER_HALF_BIT (>=1).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready (after first post-reset edge); accepts i_TX_DV
// ST_XFER | 16 SCLK toggles in flight; i_TX_DV ignored, not queued
module spi_master
  import spi_pkg::*;
#(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 1
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_SPI_Clk,
  output logic       o_SPI_MOSI,
  input  logic       i_SPI_MISO
);

  localparam spi_mode_e MODE = spi_mode_e'(2'(SPI_MODE));
  localparam logic      CPOL = cpol(MODE);
  localparam logic      CPHA = cpha(MODE);

  spi_state_e state;
  logic [7:0] tx_byte;
  logic [7:0] rx_shift;
  logic [7:0] rx_next;
  logic [2:0] tx_idx;
  logic       accept;
  logic       lead;
  logic       trail;
  logic       done;
  logic       drive_edge;
  logic       sample_edge;

  assign accept = (state == ST_IDLE) && o_TX_Ready && i_TX_DV;

  // CPHA=0 has bit 7 already on the wire at accept, so only trailing edges
  // 2..14 drive; the last trailing edge (16) just closes the burst.
  assign drive_edge  = CPHA ? lead  : (trail && !done);
  assign sample_edge = CPHA ? trail : lead;
  assign rx_next     = {rx_shift[6:0], i_SPI_MISO};

  spi_sclk_gen #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT),
    .CPOL             (CPOL)
  ) u_sclk_gen (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .start  (accept),
    .sclk   (o_SPI_Clk),
    .lead   (lead),
    .trail  (trail),
    .done   (done)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state      <= ST_IDLE;
      o_TX_Ready <= 1'b0;
      o_RX_DV    <= 1'b0;
      o_RX_Byte  <= '0;
      o_SPI_MOSI <= 1'b0;
      tx_byte    <= '0;
      rx_shift   <= '0;
      tx_idx     <= '0;
    end else begin
      o_RX_DV <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tx_byte    <= i_TX_Byte;
            o_TX_Ready <= 1'b0;
            state      <= ST_XFER;
            if (!CPHA) begin
              o_SPI_MOSI <= i_TX_Byte[7];
              tx_idx     <= 3'd6;
            end else begin
              tx_idx <= 3'd7;
            end
          end else begin
            o_TX_Ready <= 1'b1;
          end
        end
        ST_XFER: begin
          if (drive_edge) begin
            o_SPI_MOSI <= tx_byte[tx_idx];
            tx_idx     <= tx_idx - 3'd1;
          end
          if (sample_edge) begin
            rx_shift <= rx_next;
          end
          // In CPHA=1 the final sample coincides with the last edge, so the
          // completed byte has to be taken from rx_next, not rx_shift.
          if (done) begin
            o_RX_Byte  <= sample_edge ? rx_next : rx_shift;
            o_RX_DV    <= 1'b1;
            o_TX_Ready <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  localparam int NDUT = 5;

  function automatic int mode_of(input int g);
    case (g)
      0: return 0;
      1: return 3;
      2: return 0;
      3: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int n_of(input int g);
    case (g)
      0: return 1;
      1: return 4;
      2: return 2;
      3: return 3;
      default: return 2;
    endcase
  endfunction

  logic       clk;
  logic       rst;
  logic [7:0] tx_byte [NDUT];
  logic       tx_dv   [NDUT];
  logic       miso    [NDUT];
  logic       ready   [NDUT];
  logic       rx_dv   [NDUT];
  logic [7:0] rx_byte [NDUT];
  logic       sclk    [NDUT];
  logic       mosi    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    spi_master #(
      .SPI_MODE         (mode_of(g)),
      .CLKS_PER_HALF_BIT(n_of(g))
    ) u_dut (
      .i_Clk     (clk),
      .i_Reset   (rst),
      .i_TX_Byte (tx_byte[g]),
      .i_TX_DV   (tx_dv[g]),
      .o_TX_Ready(ready[g]),
      .o_RX_DV   (rx_dv[g]),
      .o_RX_Byte (rx_byte[g]),
      .o_SPI_Clk (sclk[g]),
      .o_SPI_MOSI(mosi[g]),
      .i_SPI_MISO(miso[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model state: MOSI level each DUT holds while idle
  logic last_mosi [NDUT];

  // per-cycle observations of one transfer; index c = cycles after accept edge t0
  logic       sclk_log  [0:79];
  logic       mosi_log  [0:79];
  logic       ready_log [0:79];
  logic       dv_log    [0:79];
  logic [7:0] rx_log    [0:79];
  int         n_logs;

  // ---------------- behavioural model ----------------
  function automatic logic m_cpol(input int i);
    return (mode_of(i) >= 2);
  endfunction

  function automatic logic m_cpha(input int i);
    return ((mode_of(i) % 2) == 1);
  endfunction

  // SCLK level after edge t0+c: k toggles have happened, k = c/N, 16 max.
  function automatic logic exp_sclk(input int i, input int c);
    int k;
    k = c / n_of(i);
    if (k >= 16) return m_cpol(i);
    return m_cpol(i) ^ ((k % 2) == 1);
  endfunction

  function automatic logic exp_mosi(input int i, input int c, input logic [7:0] tx, input logic prev);
    int k;
    int step;
    k = c / n_of(i);
    if (k > 16) k = 16;
    if (!m_cpha(i)) begin
      step = k / 2;
    end else begin
      if (k == 0) return prev;
      step = (k - 1) / 2;
    end
    if (step > 7) step = 7;
    return tx[7-step];
  endfunction

  // Bit index of the RX byte sampled at edge t0+e, or -1 if e is not a sampling edge.
  function automatic int sample_bit(input int i, input int e);
    int k;
    if ((e % n_of(i)) != 0) return -1;
    k = e / n_of(i);
    if (k < 1 || k > 16) return -1;
    if (!m_cpha(i) && (k % 2) == 1) return 7 - (k - 1) / 2;
    if (m_cpha(i) && (k % 2) == 0) return 7 - (k - 2) / 2;
    return -1;
  endfunction

  // ---------------- stimulus driver (records, does not judge) ----------------
  task automatic run_xfer(input int i, input logic [7:0] tx, input logic [7:0] mb,
                          input bit loopback, input int dv_at, input logic [7:0] dv_byte,
                          input int abort_at);
    int guard;
    int b;
    guard = 0;
    while (ready[i] !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    tests++;
    if (ready[i] !== 1'b1) begin
      fails++;
      $display("FAIL ready_wait dut%0d: o_TX_Ready=%b, required 1 within 200 cycles", i, ready[i]);
    end
    tx_byte[i] = tx;
    tx_dv[i]   = 1'b1;
    miso[i]    = 1'($urandom);
    @(posedge clk); #1;
    tx_dv[i] = 1'b0;
    n_logs = 16 * n_of(i) + 3;
    for (int c = 0; c < n_logs; c++) begin
      sclk_log[c]  = sclk[i];
      mosi_log[c]  = mosi[i];
      ready_log[c] = ready[i];
      dv_log[c]    = rx_dv[i];
      rx_log[c]    = rx_byte[i];
      if (c == dv_at - 1) begin
        tx_dv[i]   = 1'b1;
        tx_byte[i] = dv_byte;
      end else begin
        tx_dv[i] = 1'b0;
      end
      rst = (c == abort_at - 1);
      if (loopback) begin
        miso[i] = mosi[i];
      end else begin
        b = sample_bit(i, c + 1);
        miso[i] = (b < 0) ? 1'($urandom) : mb[b];
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      tx_dv[i]   = 1'b0;
      tx_byte[i] = 8'h00;
      miso[i]    = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      tests++;
      if (sclk[i] !== m_cpol(i)) begin fails++; $display("FAIL reset_sclk dut%0d: got %b, want %b", i, sclk[i], m_cpol(i)); end
      tests++;
      if (mosi[i] !== 1'b0) begin fails++; $display("FAIL reset_mosi dut%0d: got %b, want 0", i, mosi[i]); end
      tests++;
      if (ready[i] !== 1'b0) begin fails++; $display("FAIL reset_ready dut%0d: got %b, want 0", i, ready[i]); end
      tests++;
      if (rx_dv[i] !== 1'b0) begin fails++; $display("FAIL reset_rx_dv dut%0d: got %b, want 0", i, rx_dv[i]); end
      tests++;
      if (rx_byte[i] !== 8'h00) begin fails++; $display("FAIL reset_rx_byte dut%0d: got %h, want 00", i, rx_byte[i]); end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NDUT; i++) begin
      tests++;
      if (ready[i] !== 1'b1) begin fails++; $display("FAIL release_ready dut%0d: got %b, want 1", i, ready[i]); end
      last_mosi[i] = 1'b0;
    end
  endtask

  task automatic test_mode0_loopback();
    int rises;
    int dvs;
    int dv_c;
    int low;
    logic [7:0] rise_bits;
    rises = 0; dvs = 0; dv_c = -1; low = 0; rise_bits = 8'h00;
    run_xfer(0, 8'hA5, 8'h00, 1'b1, -1, 8'h00, -1);
    for (int c = 0; c < n_logs; c++) begin
      if (c > 0 && sclk_log[c-1] === 1'b0 && sclk_log[c] === 1'b1) begin
        rises++;
        rise_bits = {rise_bits[6:0], mosi_log[c]};
      end
      if (dv_log[c] === 1'b1) begin dvs++; dv_c = c; end
      if (ready_log[c] === 1'b0) low++;
    end
    tests++;
    if (rises != 8) begin fails++; $display("FAIL m0_sclk_rises: got %0d, want 8", rises); end
    tests++;
    if (rise_bits !== 8'hA5) begin fails++; $display("FAIL m0_mosi_bits: got %h, want a5", rise_bits); end
    tests++;
    if (dvs != 1 || dv_c != 16) begin fails++; $display("FAIL m0_rx_dv: got %0d pulses at c=%0d, want 1 at c=16", dvs, dv_c); end
    tests++;
    if (rx_log[16] !== 8'hA5) begin fails++; $display("FAIL m0_rx_byte: got %h, want a5", rx_log[16]); end
    tests++;
    if (low != 16) begin fails++; $display("FAIL m0_ready_low: got %0d cycles, want 16", low); end
    last_mosi[0] = 1'b1;
  endtask

  task automatic test_mode3();
    logic [7:0] tx;
    logic [7:0] fall_bits;
    int bad_moves;
    int low;
    int dv_c;
    tx = 8'($urandom);
    fall_bits = 8'h00; bad_moves = 0; low = 0; dv_c = -1;
    tests++;
    if (sclk[1] !== 1'b1) begin fails++; $display("FAIL m3_idle_sclk: got %b, want 1", sclk[1]); end
    run_xfer(1, tx, 8'h3C, 1'b0, -1, 8'h00, -1);
    for (int c = 0; c < n_logs; c++) begin
      if (c > 0 && sclk_log[c-1] === 1'b1 && sclk_log[c] === 1'b0)
        fall_bits = {fall_bits[6:0], mosi_log[c]};
      if (c > 0 && mosi_log[c] !== mosi_log[c-1] && !(sclk_log[c-1] === 1'b1 && sclk_log[c] === 1'b0))
        bad_moves++;
      if (ready_log[c] === 1'b0) low++;
      if (dv_log[c] === 1'b1 && dv_c < 0) dv_c = c;
    end
    tests++;
    if (fall_bits !== tx) begin fails++; $display("FAIL m3_mosi_bits: got %h, want %h", fall_bits, tx); end
    tests++;
    if (bad_moves != 0) begin fails++; $display("FAIL m3_mosi_off_edge: got %0d changes, want 0", bad_moves); end
    tests++;
    if (low != 64 || dv_c != 64) begin fails++; $display("FAIL m3_length: got low=%0d dv_at=%0d, want 64/64", low, dv_c); end
    tests++;
    if (rx_log[64] !== 8'h3C) begin fails++; $display("FAIL m3_rx_byte: got %h, want 3c", rx_log[64]); end
    tests++;
    if (sclk_log[66] !== 1'b1) begin fails++; $display("FAIL m3_sclk_after: got %b, want 1", sclk_log[66]); end
    last_mosi[1] = tx[0];
  endtask

  task automatic test_back_to_back();
    int guard;
    int npulse;
    int first_c;
    int second_c;
    logic [7:0] b0;
    logic [7:0] b1;
    guard = 0; npulse = 0; first_c = -1; second_c = -1; b0 = 8'hxx; b1 = 8'hxx;
    while (ready[0] !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    tx_byte[0] = 8'h00;
    tx_dv[0]   = 1'b1;
    miso[0]    = mosi[0];
    @(posedge clk); #1;
    tx_dv[0] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rx_dv[0] === 1'b1) begin
        npulse++;
        if (npulse == 1) begin first_c = c; b0 = rx_byte[0]; end
        else if (npulse == 2) begin second_c = c; b1 = rx_byte[0]; end
      end
      if (c == 16) begin
        tx_dv[0]   = 1'b1;
        tx_byte[0] = 8'hFF;
      end else begin
        tx_dv[0] = 1'b0;
      end
      miso[0] = mosi[0];
      @(posedge clk); #1;
    end
    tests++;
    if (npulse != 2) begin fails++; $display("FAIL b2b_pulses: got %0d, want 2", npulse); end
    tests++;
    if (first_c != 16 || second_c - first_c != 17) begin fails++; $display("FAIL b2b_spacing: got first=%0d gap=%0d, want 16/17", first_c, second_c - first_c); end
    tests++;
    if (b0 !== 8'h00 || b1 !== 8'hFF) begin fails++; $display("FAIL b2b_bytes: got %h %h, want 00 ff", b0, b1); end
    last_mosi[0] = 1'b1;
  endtask

  task automatic test_ignore_dv();
    logic [7:0] tx;
    int dvs;
    int bad;
    tx = 8'($urandom);
    dvs = 0; bad = 0;
    run_xfer(0, tx, 8'h00, 1'b1, 5, ~tx, -1);
    for (int c = 0; c < n_logs; c++) begin
      if (dv_log[c] === 1'b1) dvs++;
      if (mosi_log[c] !== exp_mosi(0, c, tx, last_mosi[0])) bad++;
    end
    tests++;
    if (dvs != 1) begin fails++; $display("FAIL ign_rx_dv: got %0d pulses, want 1", dvs); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL ign_mosi: got %0d wrong cycles, want 0 (tx=%h)", bad, tx); end
    tests++;
    if (rx_log[16] !== tx) begin fails++; $display("FAIL ign_rx_byte: got %h, want %h", rx_log[16], tx); end
    tests++;
    if (ready_log[17] !== 1'b1 || ready_log[18] !== 1'b1) begin fails++; $display("FAIL ign_not_queued: got ready %b%b, want 11", ready_log[17], ready_log[18]); end
    last_mosi[0] = tx[0];
  endtask

  task automatic test_reset_abort();
    logic [7:0] tx;
    logic [7:0] mb;
    int dvs;
    int bad;
    tx = 8'($urandom) | 8'h80;
    dvs = 0; bad = 0;
    run_xfer(2, tx, 8'($urandom), 1'b0, -1, 8'h00, 8);
    for (int c = 0; c < n_logs; c++) begin
      if (dv_log[c] === 1'b1) dvs++;
      if (rx_log[c] !== 8'h00) bad++;
    end
    tests++;
    if (sclk_log[8] !== 1'b0 || mosi_log[8] !== 1'b0 || ready_log[8] !== 1'b0) begin
      fails++; $display("FAIL abort_outputs: got sclk=%b mosi=%b ready=%b, want 0 0 0", sclk_log[8], mosi_log[8], ready_log[8]);
    end
    tests++;
    if (ready_log[9] !== 1'b1) begin fails++; $display("FAIL abort_ready_release: got %b, want 1", ready_log[9]); end
    tests++;
    if (dvs != 0 || bad != 0) begin fails++; $display("FAIL abort_no_rx: got %0d pulses, %0d byte changes, want 0 0", dvs, bad); end
    for (int i = 0; i < NDUT; i++) last_mosi[i] = 1'b0;
    mb = 8'($urandom);
    bad = 0; dvs = 0;
    run_xfer(2, 8'h81, mb, 1'b0, -1, 8'h00, -1);
    for (int c = 0; c < n_logs; c++) begin
      if (mosi_log[c] !== exp_mosi(2, c, 8'h81, last_mosi[2])) bad++;
      if (dv_log[c] === 1'b1) dvs++;
    end
    tests++;
    if (bad != 0 || dvs != 1 || dv_log[32] !== 1'b1) begin fails++; $display("FAIL abort_retry: got %0d mosi errors, %0d pulses, want 0 1", bad, dvs); end
    tests++;
    if (rx_log[32] !== mb) begin fails++; $display("FAIL abort_retry_rx: got %h, want %h", rx_log[32], mb); end
    last_mosi[2] = 1'b1;
  endtask

  task automatic test_mode1_mode2();
    logic [7:0] tx;
    int e;
    for (int i = 3; i <= 4; i++) begin
      tx = 8'($urandom);
      tests++;
      if (sclk[i] !== m_cpol(i)) begin fails++; $display("FAIL m%0d_idle_sclk: got %b, want %b", mode_of(i), sclk[i], m_cpol(i)); end
      run_xfer(i, tx, 8'h96, 1'b0, -1, 8'h00, -1);
      e = 16 * n_of(i);
      tests++;
      if (dv_log[e] !== 1'b1 || rx_log[e] !== 8'h96) begin fails++; $display("FAIL m%0d_rx: got dv=%b byte=%h, want 1 96", mode_of(i), dv_log[e], rx_log[e]); end
      tests++;
      if (sclk_log[e+1] !== m_cpol(i)) begin fails++; $display("FAIL m%0d_sclk_after: got %b, want %b", mode_of(i), sclk_log[e+1], m_cpol(i)); end
      last_mosi[i] = tx[0];
    end
  endtask

  task automatic test_random();
    logic [7:0] tx;
    logic [7:0] mb;
    int e;
    for (int i = 0; i < NDUT; i++) begin
      for (int r = 0; r < 3; r++) begin
        tx = 8'($urandom);
        mb = 8'($urandom);
        run_xfer(i, tx, mb, 1'b0, -1, 8'h00, -1);
        e = 16 * n_of(i);
        for (int c = 0; c < n_logs; c++) begin
          tests++;
          if (sclk_log[c] !== exp_sclk(i, c)) begin fails++; $display("FAIL rnd_sclk dut%0d c=%0d: got %b, want %b", i, c, sclk_log[c], exp_sclk(i, c)); end
          tests++;
          if (mosi_log[c] !== exp_mosi(i, c, tx, last_mosi[i])) begin fails++; $display("FAIL rnd_mosi dut%0d c=%0d tx=%h: got %b, want %b", i, c, tx, mosi_log[c], exp_mosi(i, c, tx, last_mosi[i])); end
          tests++;
          if (ready_log[c] !== (c >= e)) begin fails++; $display("FAIL rnd_ready dut%0d c=%0d: got %b, want %b", i, c, ready_log[c], (c >= e)); end
          tests++;
          if (dv_log[c] !== (c == e)) begin fails++; $display("FAIL rnd_rx_dv dut%0d c=%0d: got %b, want %b", i, c, dv_log[c], (c == e)); end
        end
        tests++;
        if (rx_log[e] !== mb) begin fails++; $display("FAIL rnd_rx_byte dut%0d: got %h, want %h", i, rx_log[e], mb); end
        last_mosi[i] = tx[0];
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_mode0_loopback();
    test_mode3();
    test_back_to_back();
    test_ignore_dv();
    test_reset_abort();
    test_mode1_mode2();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
